// File: rtl/tile_draw_scheduler_pkg.sv
// Shared constants, state encoding and job record for the tile/screen draw scheduler.
package tile_draw_scheduler_pkg;
    localparam int GRID_W = 20;
    localparam int GRID_H = 15;
    localparam int SCR_W  = 320;
    localparam int SCR_H  = 240;

    localparam logic [1:0] MEM_TITLE   = 2'd0;
    localparam logic [1:0] MEM_GAME    = 2'd1;
    localparam logic [1:0] MEM_END     = 2'd2;
    localparam logic [1:0] MEM_TILESET = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        BUSY  = ST_BUSY,
        DONE  = ST_DONE
    } state_e;

    typedef struct packed {
        logic       is_tile;
        logic [1:0] mem_sel;
        logic [3:0] tile;
        logic [4:0] col;
        logic [3:0] row;
    } job_t;
endpackage

// File: rtl/tile_draw_scheduler_rr_arbiter.sv
// Round-robin pick among NREQ requesters, search starting at ptr.
module tile_draw_scheduler_rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);
    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = PW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tile_draw_scheduler.sv
// Arbitrates screen and tile draw jobs onto the copy engine and maps its pixel
// offsets onto VGA plot coordinates.
module tile_draw_scheduler
    import tile_draw_scheduler_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scr_req,
    input  logic [1:0]        scr_sel,
    output logic              scr_ack,
    input  logic [NREQ-1:0]   t_req,
    input  logic [NREQ*5-1:0] t_col,
    input  logic [NREQ*4-1:0] t_row,
    input  logic [NREQ*4-1:0] t_tile,
    output logic [NREQ-1:0]   t_ack,
    output logic              req_err,
    output logic              cp_go,
    output logic [1:0]        cp_mem_sel,
    output logic [3:0]        cp_tile_sel,
    input  logic [16:0]       cp_offset,
    input  logic [2:0]        cp_colour,
    input  logic              cp_write_en,
    input  logic              cp_finished,
    output logic [8:0]        vga_x,
    output logic [7:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot,
    output logic              busy,
    output logic              done
);
    state_e          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   tidx_q, tidx_d;
    job_t            job_q, job_d;
    logic            rej_scr_q, rej_scr_d;
    logic [NREQ-1:0] rej_t_q, rej_t_d;

    logic [NREQ-1:0] arb_grant;
    logic [PW-1:0]   arb_idx;
    logic            arb_any;
    logic [4:0]      win_col;
    logic [3:0]      win_row;
    logic [3:0]      win_tile;
    logic            rej_pend;
    logic            tile_go;

    tile_draw_scheduler_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (t_req),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign win_col  = t_col[5*arb_idx +: 5];
    assign win_row  = t_row[4*arb_idx +: 4];
    assign win_tile = t_tile[4*arb_idx +: 4];
    // Reject acks are registered; hold off arbitration for that one cycle so
    // the still-asserted request is not judged twice.
    assign rej_pend = rej_scr_q | (|rej_t_q);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        tidx_d    = tidx_q;
        job_d     = job_q;
        rej_scr_d = 1'b0;
        rej_t_d   = '0;
        case (state_q)
            IDLE: begin
                if (!rej_pend) begin
                    if (scr_req) begin
                        if (scr_sel == MEM_TILESET) begin
                            rej_scr_d = 1'b1;
                        end else begin
                            job_d         = '0;
                            job_d.mem_sel = scr_sel;
                            state_d       = START;
                        end
                    end else if (arb_any) begin
                        rr_ptr_d = (arb_idx == PW'(NREQ-1)) ? '0 : arb_idx + PW'(1);
                        if (win_col >= 5'(GRID_W) || win_row >= 4'(GRID_H)) begin
                            rej_t_d = arb_grant;
                        end else begin
                            job_d.is_tile = 1'b1;
                            job_d.mem_sel = MEM_TILESET;
                            job_d.tile    = win_tile;
                            job_d.col     = win_col;
                            job_d.row     = win_row;
                            tidx_d        = arb_idx;
                            state_d       = START;
                        end
                    end
                end
            end
            START:   state_d = BUSY;
            BUSY:    if (cp_finished) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            tidx_q    <= '0;
            job_q     <= '0;
            rej_scr_q <= 1'b0;
            rej_t_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            tidx_q    <= tidx_d;
            job_q     <= job_d;
            rej_scr_q <= rej_scr_d;
            rej_t_q   <= rej_t_d;
        end
    end

    assign cp_go       = (state_q == START);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign tile_go     = cp_go & job_q.is_tile;
    assign scr_ack     = (cp_go & ~job_q.is_tile) | rej_scr_q;
    assign t_ack       = rej_t_q | (NREQ'(tile_go) << tidx_q);
    assign req_err     = rej_pend;
    assign cp_mem_sel  = job_q.mem_sel;
    assign cp_tile_sel = job_q.tile;

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (state_q == BUSY) begin
            vga_plot   = cp_write_en;
            vga_colour = cp_colour;
            if (job_q.is_tile) begin
                vga_x = {job_q.col, 4'b0} + {5'b0, cp_offset[3:0]};
                vga_y = {job_q.row, 4'b0} + {4'b0, cp_offset[7:4]};
            end else begin
                vga_x = cp_offset[8:0];
                vga_y = cp_offset[16:9];
            end
        end
    end
endmodule

// File: tb/tb_tile_draw_scheduler.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_tile_draw_scheduler;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        scr_req;
    logic [1:0]  scr_sel;
    logic        scr_ack;
    logic [3:0]  t_req;
    logic [19:0] t_col;
    logic [15:0] t_row;
    logic [15:0] t_tile;
    logic [3:0]  t_ack;
    logic        req_err, cp_go;
    logic [1:0]  cp_mem_sel;
    logic [3:0]  cp_tile_sel;
    logic [16:0] cp_offset;
    logic [2:0]  cp_colour;
    logic        cp_write_en, cp_finished;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot, busy, done;

    tile_draw_scheduler #(.NREQ(4)) dut (
        .clk(clk), .reset_n(reset_n), .scr_req(scr_req), .scr_sel(scr_sel), .scr_ack(scr_ack),
        .t_req(t_req), .t_col(t_col), .t_row(t_row), .t_tile(t_tile), .t_ack(t_ack),
        .req_err(req_err), .cp_go(cp_go), .cp_mem_sel(cp_mem_sel), .cp_tile_sel(cp_tile_sel),
        .cp_offset(cp_offset), .cp_colour(cp_colour), .cp_write_en(cp_write_en),
        .cp_finished(cp_finished), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       scr_ack;
        logic [3:0] t_ack;
        logic       err;
        logic       go;
        logic [1:0] mem;
        logic [3:0] tile;
        logic       done;
        logic       busy;
        logic       plot;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] col;
    } ev_t;

    ev_t exp_q[$];
    int  chk_cnt  = 0;
    int  pass_cnt = 0;
    int  ev_n     = 0;
    bit  eng_stall = 1'b0;
    bit  fin_prev  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, got, exp);
    endtask

    // Monitor: every cycle with an ack/err/go/done/plot is one scoreboard event.
    always @(negedge clk) begin
        ev_t o, e;
        if (reset_n) begin
            if (fin_prev) check("done_after_finished", 32'(done), 32'd1);
            fin_prev = cp_finished && busy;
            o = '0;
            o.scr_ack = scr_ack;  o.t_ack = t_ack;  o.err = req_err;  o.go = cp_go;
            o.mem  = cp_go ? cp_mem_sel : 2'd0;
            o.tile = cp_go ? cp_tile_sel : 4'd0;
            o.done = done;  o.busy = busy;  o.plot = vga_plot;
            o.x   = vga_plot ? vga_x : 9'd0;
            o.y   = vga_plot ? vga_y : 8'd0;
            o.col = vga_plot ? vga_colour : 3'd0;
            if (scr_ack || (|t_ack) || req_err || cp_go || done || vga_plot) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event %0d: got %h want none", ev_n, o);
                end else begin
                    e = exp_q.pop_front();
                    if (o === e) pass_cnt++;
                    else $display("FAIL event %0d: got %h want %h", ev_n, o, e);
                end
                ev_n++;
            end
        end
    end

    task automatic push_tile_job(input int i, input int col, input int row, input int tile, input bit full);
        ev_t e;
        e = '0; e.t_ack = 4'(1 << i); e.go = 1'b1; e.mem = 2'd3; e.tile = 4'(tile); e.busy = 1'b1;
        exp_q.push_back(e);
        if (full) begin
            for (int ty = 0; ty < 16; ty++)
                for (int tx = 0; tx < 16; tx++) begin
                    e = '0; e.busy = 1'b1; e.plot = 1'b1;
                    e.x = 9'(col*16 + tx); e.y = 8'(row*16 + ty); e.col = 3'(tx + ty);
                    exp_q.push_back(e);
                end
            e = '0; e.done = 1'b1; e.busy = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_scr_job(input logic [1:0] sel);
        ev_t e;
        e = '0; e.scr_ack = 1'b1; e.go = 1'b1; e.mem = sel; e.busy = 1'b1;
        exp_q.push_back(e);
        e = '0; e.busy = 1'b1; e.plot = 1'b1; e.x = 9'd0;   e.y = 8'd0;   e.col = 3'd1; exp_q.push_back(e);
        e = '0; e.busy = 1'b1; e.plot = 1'b1; e.x = 9'd160; e.y = 8'd120; e.col = 3'd2; exp_q.push_back(e);
        e = '0; e.busy = 1'b1; e.plot = 1'b1; e.x = 9'd319; e.y = 8'd239; e.col = 3'd3; exp_q.push_back(e);
        e = '0; e.done = 1'b1; e.busy = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_reject(input bit is_scr, input int i);
        ev_t e;
        e = '0; e.err = 1'b1;
        if (is_scr) e.scr_ack = 1'b1; else e.t_ack = 4'(1 << i);
        exp_q.push_back(e);
    endtask

    task automatic wait_tack(input int i);
        bit got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (t_ack[i]) begin got = 1'b1; break; end
        end
        check($sformatf("t_ack%0d_seen", i), 32'(got), 32'd1);
    endtask

    task automatic tile_req(input int i, input int col, input int row, input int tile, input bit drop);
        t_col[5*i +: 5]  = 5'(col);
        t_row[4*i +: 4]  = 4'(row);
        t_tile[4*i +: 4] = 4'(tile);
        t_req[i] = 1'b1;
        wait_tack(i);
        if (drop) t_req[i] = 1'b0;
    endtask

    task automatic scr_request(input logic [1:0] sel);
        bit got = 1'b0;
        scr_sel = sel;
        scr_req = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (scr_ack) begin got = 1'b1; break; end
        end
        check("scr_ack_seen", 32'(got), 32'd1);
        scr_req = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 4000 && exp_q.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("idle_after_job", 32'(busy), 32'd0);
    endtask

    // Copy engine stand-in: walks a tile fully, a screen at three sample points.
    task automatic run_engine();
        if (eng_stall) begin
            for (int c = 0; c < 500; c++) begin
                @(posedge clk);
                if (!reset_n) return;
            end
            return;
        end
        if (cp_mem_sel == 2'd3) begin
            for (int ty = 0; ty < 16; ty++)
                for (int tx = 0; tx < 16; tx++) begin
                    @(posedge clk); #1;
                    cp_write_en = 1'b1;
                    cp_offset   = {9'd0, 4'(ty), 4'(tx)};
                    cp_colour   = 3'(tx + ty);
                end
        end else begin
            for (int p = 0; p < 3; p++) begin
                @(posedge clk); #1;
                cp_write_en = 1'b1;
                cp_offset   = (p == 0) ? 17'd0 : (p == 1) ? {8'd120, 9'd160} : {8'd239, 9'd319};
                cp_colour   = 3'(p + 1);
            end
        end
        @(posedge clk); #1;
        cp_write_en = 1'b0; cp_offset = '0; cp_finished = 1'b1;
        @(posedge clk); #1;
        cp_finished = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_go_ack", 32'({cp_go, scr_ack, t_ack, req_err, done}), 32'd0);
        check("rst_sel",   32'({cp_mem_sel, cp_tile_sel}), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; scr_req = 1'b0; scr_sel = '0; t_req = '0;
        t_col = '0; t_row = '0; t_tile = '0;
        cp_offset = '0; cp_colour = '0; cp_write_en = 1'b0; cp_finished = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (reset_n && cp_go) run_engine();
            end
        join_none
        do_reset();

        // Stray engine strobes while idle must not plot or start anything.
        cp_write_en = 1'b1; cp_offset = 17'h1ffff; cp_colour = 3'd7; cp_finished = 1'b1;
        @(negedge clk);
        check("idle_plot",   32'(vga_plot), 32'd0);
        check("idle_xy",     32'({vga_x, vga_y, vga_colour}), 32'd0);
        cp_write_en = 1'b0; cp_offset = '0; cp_colour = '0; cp_finished = 1'b0;
        @(negedge clk);
        check("idle_no_busy", 32'({busy, done}), 32'd0);

        // Basic tile: (3,2) tile 5 -> plots (48,32)..(63,47).
        push_tile_job(1, 3, 2, 5, 1'b1);
        tile_req(1, 3, 2, 5, 1'b1);
        drain();

        // Rejects: column 20, row 15, screen select 3.
        push_reject(1'b0, 2);
        tile_req(2, 20, 0, 0, 1'b1);
        drain();
        push_reject(1'b0, 3);
        tile_req(3, 0, 15, 0, 1'b1);
        drain();
        push_reject(1'b1, 0);
        scr_request(2'd3);
        drain();

        // Screen and tile together: screen first, then corner tile (304..319, 224..239).
        push_scr_job(2'd1);
        push_tile_job(0, 19, 14, 15, 1'b1);
        fork
            scr_request(2'd1);
            tile_req(0, 19, 14, 15, 1'b1);
        join
        drain();

        // Round robin from ptr 0 with req 0 and 2; re-raised req 0 waits for 2.
        do_reset();
        push_tile_job(0, 2, 3, 7, 1'b1);
        push_tile_job(2, 5, 6, 8, 1'b1);
        push_tile_job(0, 7, 9, 1, 1'b1);
        fork
            begin
                tile_req(0, 2, 3, 7, 1'b1);
                @(negedge clk);
                tile_req(0, 7, 9, 1, 1'b1);
            end
            tile_req(2, 5, 6, 8, 1'b1);
        join
        drain();

        // Reset mid-job: job abandoned silently, held request granted again.
        eng_stall = 1'b1;
        push_tile_job(3, 1, 1, 2, 1'b0);
        tile_req(3, 1, 1, 2, 1'b0);
        repeat (3) @(negedge clk);
        check("midjob_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        eng_stall = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_outs", 32'({cp_go, scr_ack, t_ack, req_err, done, vga_plot}), 32'd0);
        reset_n = 1'b1;
        push_tile_job(3, 1, 1, 2, 1'b1);
        wait_tack(3);
        t_req[3] = 1'b0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
